// File: rtl/decode_ctrl_pipe.sv
// LEGv8 main decoder with ID/EX control register, load-use stall and flush handling.
// Optional perf counters (stall/flush) are built when DECODE_PERF_CNT_EN is defined.
module decode_ctrl_pipe #(
  parameter int REG_W   = 5,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               instr_valid_i,
  input  logic               flush_i,
  output logic [REG_W-1:0]   rn_o,
  output logic [REG_W-1:0]   rm_o,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [9:0]         ex_ctrl_o,
  output logic [REG_W-1:0]   ex_rd_o,
  output logic               ex_illegal_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  // ex_ctrl bit positions: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
  //                         Branch, UncondBr, ALUOp[1:0], ImmSel}
  localparam int CTRL_MEMREAD = 6;

  logic [10:0]      opcode;
  logic             reg2loc;
  logic [9:0]       ctrl;
  logic             use_rn;
  logic             use_rm;
  logic             illegal;
  logic             haz;
  logic             load_bubble;
  logic             unused_bits;

  assign opcode      = instr_i[INSTR_W-1 -: 11];
  assign unused_bits = ^instr_i[15:10];

  always_comb begin
    reg2loc = 1'b0;
    ctrl    = '0;
    use_rn  = 1'b0;
    use_rm  = 1'b0;
    illegal = 1'b0;
    casez (opcode)
      11'b11111000010: begin // LDUR
        ctrl   = 10'b1111000000;
        use_rn = 1'b1;
      end
      11'b11111000000: begin // STUR
        reg2loc = 1'b1;
        ctrl    = 10'b1000100000;
        use_rn  = 1'b1;
        use_rm  = 1'b1;
      end
      11'b10110100???: begin // CBZ
        reg2loc = 1'b1;
        ctrl    = 10'b0000010010;
        use_rm  = 1'b1;
      end
      11'b10110101???: begin // CBNZ
        reg2loc = 1'b1;
        ctrl    = 10'b0000010110;
        use_rm  = 1'b1;
      end
      11'b1?001011000,
      11'b10?01010000: begin // ADD/SUB, AND/ORR
        ctrl   = 10'b0010000100;
        use_rn = 1'b1;
        use_rm = 1'b1;
      end
      11'b1?01000100?: begin // ADDI/SUBI
        ctrl   = 10'b1010000101;
        use_rn = 1'b1;
      end
      11'b000101?????: begin // B
        ctrl = 10'b0000001000;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign rn_o = instr_i[2*REG_W-1:REG_W];
  assign rm_o = reg2loc ? instr_i[REG_W-1:0] : instr_i[16+REG_W-1:16];

  // X31 is the zero register, so a load into it never creates a dependency.
  assign haz = instr_valid_i & ex_valid_o & ex_ctrl_o[CTRL_MEMREAD]
             & (ex_rd_o != {REG_W{1'b1}})
             & ((use_rn & (ex_rd_o == rn_o)) | (use_rm & (ex_rd_o == rm_o)));

  assign stall_o     = haz & ~flush_i;
  assign load_bubble = flush_i | stall_o | ~instr_valid_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= '0;
      ex_rd_o      <= '0;
      ex_illegal_o <= 1'b0;
    end else if (load_bubble) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl_o    <= '0;
      ex_rd_o      <= '0;
      ex_illegal_o <= 1'b0;
    end else begin
      ex_valid_o   <= 1'b1;
      ex_ctrl_o    <= ctrl;
      ex_rd_o      <= instr_i[REG_W-1:0];
      ex_illegal_o <= illegal;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating counters; cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_o && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_i && instr_valid_i && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode sweep, load-use stalls, flush priority,
// reset behaviour and (when DECODE_PERF_CNT_EN is defined) saturating counters at CNT_W=2.
module tb_decode_ctrl_pipe;
  localparam int REG_W   = 5;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [INSTR_W-1:0] instr;
  logic               valid;
  logic               flush;
  logic [REG_W-1:0]   rn;
  logic [REG_W-1:0]   rm;
  logic               stall;
  logic               ex_valid;
  logic [9:0]         ex_ctrl;
  logic [REG_W-1:0]   ex_rd;
  logic               ex_illegal;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stall = 0;
  int n_flush = 0;

  logic [31:0] sw_i    [11];
  logic [9:0]  sw_ctrl [11];
  logic        sw_ill  [11];
  logic [4:0]  sw_rd   [11];

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.REG_W(REG_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_i       (instr),
    .instr_valid_i (valid),
    .flush_i       (flush),
    .rn_o          (rn),
    .rm_o          (rm),
    .stall_o       (stall),
    .ex_valid_o    (ex_valid),
    .ex_ctrl_o     (ex_ctrl),
    .ex_rd_o       (ex_rd),
    .ex_illegal_o  (ex_illegal),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic f);
    instr = i;
    valid = v;
    flush = f;
    #1;
  endtask

  function automatic int sat(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic chk_counters(input string tag);
`ifdef DECODE_PERF_CNT_EN
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), sat(n_stall));
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), sat(n_flush));
`else
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sw_i = '{32'hF8000107, 32'hB4000003, 32'hB5000004, 32'h8B040043, 32'hCB020029,
             32'h8A00000A, 32'hAA00000B, 32'hD100000C, 32'h14000005, 32'hF8400022,
             32'hFFE0000D};
    sw_ctrl = '{10'h220, 10'h012, 10'h016, 10'h084, 10'h084,
                10'h084, 10'h084, 10'h285, 10'h008, 10'h3C0, 10'h000};
    sw_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    sw_rd   = '{5'd7, 5'd3, 5'd4, 5'd3, 5'd9, 5'd10, 5'd11, 5'd12, 5'd5, 5'd2, 5'd13};

    // Reset held with live random instructions
    reset = 1'b0;
    drive($urandom, 1'b1, 1'b0);
    tick;
    drive($urandom, 1'b1, 1'b0);
    tick;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ex_rd", 32'(ex_rd), 0);
    chk("rst_ex_illegal", 32'(ex_illegal), 0);
    chk_counters("rst");

    // Release reset: ADDI X1, X1, #1
    drive(32'h91000421, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("addi_rn", 32'(rn), 1);
    tick;
    chk("addi_ex_valid", 32'(ex_valid), 1);
    chk("addi_ex_ctrl", 32'(ex_ctrl), 32'h285);
    chk("addi_ex_rd", 32'(ex_rd), 1);

    // Decode sweep
    for (int k = 0; k < 11; k++) begin
      drive(sw_i[k], 1'b1, 1'b0);
      chk($sformatf("sweep%0d_stall", k), 32'(stall), 0);
      tick;
      chk($sformatf("sweep%0d_valid", k), 32'(ex_valid), 1);
      chk($sformatf("sweep%0d_ctrl", k), 32'(ex_ctrl), 32'(sw_ctrl[k]));
      chk($sformatf("sweep%0d_illegal", k), 32'(ex_illegal), 32'(sw_ill[k]));
      chk($sformatf("sweep%0d_rd", k), 32'(ex_rd), 32'(sw_rd[k]));
    end

    // Invalid slot loads a bubble
    drive(32'h8B040043, 1'b0, 1'b0);
    tick;
    chk("novalid_ex_valid", 32'(ex_valid), 0);
    chk("novalid_ex_ctrl", 32'(ex_ctrl), 0);
    chk("novalid_ex_rd", 32'(ex_rd), 0);

    // Load-use on rn: LDUR X2,[X1] then ADD X3,X2,X4
    drive(32'hF8400022, 1'b1, 1'b0);
    tick;
    drive(32'h8B040043, 1'b1, 1'b0);
    chk("lu_rn", 32'(rn), 2);
    chk("lu_rm", 32'(rm), 4);
    chk("lu_stall", 32'(stall), 1);
    n_stall++;
    tick;
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_ctrl", 32'(ex_ctrl), 0);
    chk("lu_stall_released", 32'(stall), 0);
    tick;
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_ctrl", 32'(ex_ctrl), 32'h084);
    chk("lu_add_rd", 32'(ex_rd), 3);

    // Load into X31 never stalls
    drive(32'hF840003F, 1'b1, 1'b0);
    tick;
    drive(32'h8B0403E3, 1'b1, 1'b0);
    chk("x31_stall", 32'(stall), 0);
    tick;
    chk("x31_add_ctrl", 32'(ex_ctrl), 32'h084);

    // Load-use on rm: LDUR X4 then ADD X3,X2,X4
    drive(32'hF8400024, 1'b1, 1'b0);
    tick;
    drive(32'h8B040043, 1'b1, 1'b0);
    chk("lurm_stall", 32'(stall), 1);
    n_stall++;
    tick;
    chk("lurm_bubble_valid", 32'(ex_valid), 0);
    tick;
    chk("lurm_add_valid", 32'(ex_valid), 1);

    // STUR source via Reg2Loc: LDUR X5 then STUR X5,[X6]
    drive(32'hF8400025, 1'b1, 1'b0);
    tick;
    drive(32'hF80000C5, 1'b1, 1'b0);
    chk("stur_rm", 32'(rm), 5);
    chk("stur_rn", 32'(rn), 6);
    chk("stur_stall", 32'(stall), 1);
    n_stall++;
    tick;
    chk("stur_bubble_valid", 32'(ex_valid), 0);
    tick;
    chk("stur_ctrl", 32'(ex_ctrl), 32'h220);

    // Flush wins over a load-use hazard
    drive(32'hF8400022, 1'b1, 1'b0);
    tick;
    drive(32'h8B040043, 1'b1, 1'b1);
    chk("flush_stall", 32'(stall), 0);
    n_flush++;
    tick;
    chk("flush_ex_valid", 32'(ex_valid), 0);
    chk("flush_ex_ctrl", 32'(ex_ctrl), 0);
    drive(32'h8B040043, 1'b1, 1'b0);
    tick;
    chk("post_flush_ctrl", 32'(ex_ctrl), 32'h084);

    // Two more load-use stalls to push stall count past saturation
    for (int k = 0; k < 2; k++) begin
      drive(32'hF8400022, 1'b1, 1'b0);
      tick;
      drive(32'h8B040043, 1'b1, 1'b0);
      chk($sformatf("sat%0d_stall", k), 32'(stall), 1);
      n_stall++;
      tick;
      tick;
    end
    chk_counters("sat");

    // Reset asserted mid-stall clears the stall immediately
    drive(32'hF8400022, 1'b1, 1'b0);
    tick;
    drive(32'h8B040043, 1'b1, 1'b0);
    chk("midrst_pre_stall", 32'(stall), 1);
    reset = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_ex_valid", 32'(ex_valid), 0);
    n_stall = 0;
    n_flush = 0;
    chk_counters("midrst");
    tick;
    reset = 1'b1;
    tick;
    chk("post_rst_ctrl", 32'(ex_ctrl), 32'h084);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Next-generation LEGv8 main decoder: decodes the 11-bit opcode field into the control bundle and registers it into the ID/EX stage.
- Sits between the IF/ID register and the execute stage.
- Over the previous combinational decoder it adds ADDI, SUBI and B, selects the register-read addresses, detects load-use hazards with stall/bubble insertion, and flushes on taken branches.

Parameters:
- REG_W, 5, register address width.
- INSTR_W, 32, instruction width; opcode is instr_i[INSTR_W-1 -: 11].
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_i  in  INSTR_W  instruction from the IF/ID register.
- instr_valid_i  in  1  instr_i holds a real instruction.
- flush_i  in  1  taken branch resolved; kill the ID-stage instruction.
- rn_o  out  REG_W  read address 1 = instr_i[9:5] (combinational).
- rm_o  out  REG_W  read address 2 = Reg2Loc ? instr_i[4:0] : instr_i[20:16] (combinational).
- stall_o  out  1  load-use stall; freezes PC and IF/ID (combinational).
- ex_valid_o  out  1  ID/EX holds a real instruction.
- ex_ctrl_o  out  10  {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBr, ALUOp[1:0], ImmSel}.
- ex_rd_o  out  REG_W  registered instr_i[4:0].
- ex_illegal_o  out  1  registered: the valid instruction had an unknown opcode.
- stall_cnt_o  out  CNT_W  stall-cycle count (optional feature).
- flush_cnt_o  out  CNT_W  flush count (optional feature).

Behaviour:
- Decode (casez on opcode); bundle given as Reg2Loc, then ex_ctrl bits in ex_ctrl_o order:
  - LDUR 11111000010: 0,1,1,1,1,0,0,0,00,0
  - STUR 11111000000: 1,1,0,0,0,1,0,0,00,0
  - CBZ 10110100???: 1,0,0,0,0,0,1,0,01,0
  - CBNZ 10110101???: 1,0,0,0,0,0,1,0,11,0
  - ADD/SUB 1?001011000 and AND/ORR 10?01010000: 0,0,0,1,0,0,0,0,10,0
  - ADDI/SUBI 1?01000100?: 0,1,0,1,0,0,0,0,10,1
  - B 000101?????: 0,0,0,0,0,0,0,1,00,0
  - Any other opcode: all zero, illegal=1.
- Register-use flags:
  - use_rn for LDUR, STUR, R-type, ADDI/SUBI.
  - use_rm for STUR, CBZ/CBNZ, R-type.
- Hazard: haz = instr_valid_i & ex_valid_o & ex_ctrl_o.MemRead & (ex_rd_o != 31) & ((use_rn & ex_rd_o==rn_o) | (use_rm & ex_rd_o==rm_o)).
- stall_o = haz & ~flush_i.
- ID/EX update each rising edge, in priority order:
  - flush_i, stall_o or ~instr_valid_i: load a bubble (ex_valid_o=0, ex_ctrl_o=0, ex_illegal_o=0, ex_rd_o=0).
  - Otherwise load the decoded bundle; ex_valid_o=1; ex_illegal_o=illegal.
  - Illegal instructions load ex_valid_o=1 with ex_ctrl_o=0 (no side effects).
- Latency: 1 cycle from instr_i to the ex_* outputs. A stall lasts exactly 1 cycle, because the bubble clears ex_valid_o.
- Reset (reset=0, async): all ex_* outputs and counters are 0. Reset asserted mid-stall clears the stall immediately, since ex_valid_o goes to 0.
- flush_i together with haz: flush wins, stall_o=0, and a bubble is loaded.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- When defined:
  - stall_cnt_o increments on every cycle with stall_o=1.
  - flush_cnt_o increments on every cycle with flush_i & instr_valid_i.
  - Both saturate at 2^CNT_W-1 and clear only on reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset: hold reset=0 with instr_valid_i=1 and random instr_i -> ex_valid_o=0, ex_ctrl_o=0, stall_o=0. Release reset -> decoded bundle appears after 1 edge.
- Decode sweep: drive each opcode, e.g. ADDI 0x91000421 -> ex_ctrl_o=1_0_1_0_0_0_0_10_1 and ex_rd_o=1. Opcode 0x7FF -> ex_illegal_o=1 and ex_ctrl_o=0.
- Load-use: LDUR X2,[X1] (0xF8400022) then ADD X3,X2,X4 -> stall_o=1 for one cycle and bubble in ID/EX; ADD issues on the next cycle. With rd=X31 -> no stall.
- STUR source hazard: LDUR X5 then STUR X5,[X6] (rm via Reg2Loc = instr[4:0]) -> stall_o=1.
- Flush priority: load-use condition together with flush_i=1 -> stall_o=0, bubble loaded, and flush_cnt_o +1 when the feature is enabled.
- Counter saturation (DECODE_PERF_CNT_EN, CNT_W=2): 5 stall cycles -> stall_cnt_o=3.
